my8cpu_in_arbiter: RTL and testbench

Shares the MY8CPU 8-bit IN port between N_REQ peripheral requesters with a round-robin policy.
- Each requester raises req with a data byte.
- The arbiter latches one winner's byte onto the CPU IN bus and holds it until the CPU signals consumption (cpu_rd).
- It then pulses ack to the winner and rotates priority.
- Sits between the peripheral layer and the MY8CPU IN input in the top level.

---
 rtl/my8cpu_pkg.sv | 21 ++
 rtl/my8cpu_rr_pick.sv | 32 +++
 rtl/my8cpu_in_arbiter.sv | 167 ++++++++++++++++
 tb/tb_my8cpu_in_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/my8cpu_pkg.sv
// Shared types and constants for the MY8CPU peripheral-side blocks.
package my8cpu_pkg;

  // Width of the MY8CPU IN/OUT data path.
  localparam int CPU_W = 8;

  // HOLD-state cycle limit used when the arbiter timeout is compiled in.
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

  // Index width for n requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/my8cpu_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// at or after ptr, wrapping from N-1 back to 0 with an explicit compare so
// that N need not be a power of two.
module my8cpu_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any
);

  // Scan ptr, ptr+1, ... and keep only the first hit.
  always_comb begin
    int idx;
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/my8cpu_in_arbiter.sv
// Round-robin arbiter sharing the MY8CPU IN port between N_REQ requesters.
// Optional HOLD timeout is compiled in with `define MY8CPU_ARB_TIMEOUT_EN;
// without it timeout_err is tied low and no counter exists.
//
// Handshakes:
//   req[i]/ack[i]       : requester holds req[i] (with stable req_data slice)
//                         until a single-cycle ack[i], and drops req[i] on the
//                         edge that ends the ack cycle.
//   cpu_in_valid/cpu_rd : cpu_in is meaningful only while cpu_in_valid is
//                         high; cpu_rd high in such a cycle consumes the byte.
//                         cpu_rd outside HOLD is ignored.
// dbg_state exposes the FSM state (arb_state_t encoding) for observation.
module my8cpu_in_arbiter
  import my8cpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = CPU_W,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [W-1:0]               cpu_in,
  output logic                       cpu_in_valid,
  input  logic                       cpu_rd,
  output logic [idx_w(N_REQ)-1:0]    grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [1:0]                 dbg_state
);

  localparam int IW = idx_w(N_REQ);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [W-1:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      pick_sel;
  logic               pick_any;
  logic [IW-1:0]      ptr_after;

`ifdef MY8CPU_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
`endif

  my8cpu_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Priority moves to the requester just after the one last granted.
  assign ptr_after = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ack_d   = '0;
`ifdef MY8CPU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          data_d  = req_data[pick_sel*W +: W];
          grant_d = pick_sel;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ARB_HOLD;
`ifdef MY8CPU_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_HOLD: begin
        if (cpu_rd) begin
          valid_d         = 1'b0;
          ack_d[grant_q]  = 1'b1;
          ptr_d           = ptr_after;
          state_d         = ARB_ACK;
        end
`ifdef MY8CPU_ARB_TIMEOUT_EN
        // A read in the terminal cycle takes precedence over the timeout.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          ptr_d   = ptr_after;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_ACK: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any latched transaction.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MY8CPU_ARB_TIMEOUT_EN
  // HOLD-cycle counter and the one-cycle timeout pulse.
  always_ff @(posedge clock) begin
    if (Reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign cpu_in       = data_q;
  assign cpu_in_valid = valid_q;
  assign ack          = ack_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_my8cpu_in_arbiter.sv
// Directed bench for my8cpu_in_arbiter (N_REQ=4, W=8, TIMEOUT=10).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, i.e. after the registered outputs have settled.
module tb_my8cpu_in_arbiter;

  localparam int N_REQ   = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 10;

  logic               clock = 1'b0;
  logic               Reset;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       cpu_in;
  logic               cpu_in_valid;
  logic               cpu_rd;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout_err;
  logic [1:0]         dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  my8cpu_in_arbiter #(
    .N_REQ   (N_REQ),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock        (clock),
    .Reset        (Reset),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .cpu_in       (cpu_in),
    .cpu_in_valid (cpu_in_valid),
    .cpu_rd       (cpu_rd),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] b);
    req_data[i*W +: W] = b;
  endtask

  // Arbiter is in IDLE with req already driven: grant, read, ack, back to IDLE.
  task automatic serve(input int id, input logic [W-1:0] b,
                       input logic [N_REQ-1:0] req_after, input logic rd_in_ack);
    tick();
    check("grant_valid", 32'(cpu_in_valid), 32'd1);
    check("grant_byte", 32'(cpu_in), 32'(b));
    check("grant_id", 32'(grant_id), 32'(id));
    check("grant_busy", 32'(busy), 32'd1);
    check("hold_state", 32'(dbg_state), 32'd1);
    check("hold_no_ack", 32'(ack), 32'd0);
    cpu_rd = 1'b1;
    tick();
    check("ack_pulse", 32'(ack), 32'(1 << id));
    check("ack_valid_low", 32'(cpu_in_valid), 32'd0);
    check("ack_busy", 32'(busy), 32'd1);
    check("ack_state", 32'(dbg_state), 32'd2);
    check("ack_no_tmo", 32'(timeout_err), 32'd0);
    cpu_rd = rd_in_ack;
    req    = req_after;
    tick();
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);
    check("byte_kept", 32'(cpu_in), 32'(b));
    check("id_kept", 32'(grant_id), 32'(id));
    cpu_rd = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    req      = 4'b1111;
    cpu_rd   = 1'b0;
    req_data = '0;
    for (int i = 0; i < N_REQ; i++) set_data(i, W'(8'h10 + i));

    // Reset held 3 cycles with all requests up: nothing granted.
    repeat (3) tick();
    check("rst_cpu_in", 32'(cpu_in), 32'd0);
    check("rst_valid", 32'(cpu_in_valid), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Release: requester 0 wins first (ptr=0). ptr becomes 1.
    Reset = 1'b0;
    serve(0, 8'h10, 4'b0000, 1'b0);

    // No requests: stays idle.
    tick();
    check("idle_valid", 32'(cpu_in_valid), 32'd0);
    check("idle_busy2", 32'(busy), 32'd0);
    check("idle_state2", 32'(dbg_state), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);

    // Single request on 2 with 8'hA5 (ptr=1 scans 1,2). ptr becomes 3.
    set_data(2, 8'hA5);
    req = 4'b0100;
    serve(2, 8'hA5, 4'b0000, 1'b0);

    // Wrap and skip: ptr=3, req=0101 -> 0 then 2; cpu_rd held through ACK.
    set_data(0, 8'h5A);
    req = 4'b0101;
    serve(0, 8'h5A, 4'b0100, 1'b1);
    serve(2, 8'hA5, 4'b0000, 1'b0);

    // cpu_rd while idle has no effect.
    cpu_rd = 1'b1;
    tick();
    check("rd_idle_state", 32'(dbg_state), 32'd0);
    check("rd_idle_valid", 32'(cpu_in_valid), 32'd0);
    check("rd_idle_ack", 32'(ack), 32'd0);
    check("rd_idle_busy", 32'(busy), 32'd0);
    cpu_rd = 1'b0;

    // Fairness from ptr=0 with all four requesting continuously.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_data(i, W'(8'h10 + i));
    req = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    while (exp_q.size() > 0) begin
      logic [1:0] id;
      id = exp_q.pop_front();
      serve(int'(id), W'(8'h10 + id), 4'b1111, 1'b0);
    end

    // Mid-transaction reset: ptr=2, only requester 1 with 8'h3C.
    set_data(1, 8'h3C);
    req = 4'b0010;
    tick();
    check("mid_valid", 32'(cpu_in_valid), 32'd1);
    check("mid_byte", 32'(cpu_in), 32'h3C);
    check("mid_grant", 32'(grant_id), 32'd1);
    Reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(cpu_in_valid), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_byte", 32'(cpu_in), 32'd0);
    Reset = 1'b0;
    req   = 4'b0000;
    cpu_rd = 1'b1;
    repeat (3) begin
      tick();
      check("mid_no_ack", 32'(ack), 32'd0);
      check("mid_idle", 32'(dbg_state), 32'd0);
    end
    cpu_rd = 1'b0;

`ifdef MY8CPU_ARB_TIMEOUT_EN
    // Timeout: grant 0, no read for TIMEOUT HOLD cycles, then requester 1.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_data(i, W'(8'h10 + i));
    req = 4'b0011;
    tick();
    check("tmo_grant", 32'(grant_id), 32'd0);
    repeat (TIMEOUT - 1) tick();
    check("tmo_still_hold", 32'(dbg_state), 32'd1);
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("tmo_pulse", 32'(timeout_err), 32'd1);
    check("tmo_no_ack", 32'(ack), 32'd0);
    check("tmo_valid", 32'(cpu_in_valid), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    tick();
    check("tmo_pulse_end", 32'(timeout_err), 32'd0);
    check("tmo_next_grant", 32'(grant_id), 32'd1);
    check("tmo_next_valid", 32'(cpu_in_valid), 32'd1);
    // Read in the terminal cycle wins over the timeout.
    repeat (TIMEOUT - 1) tick();
    cpu_rd = 1'b1;
    tick();
    check("tmo_rd_ack", 32'(ack), 32'b0010);
    check("tmo_rd_no_err", 32'(timeout_err), 32'd0);
    cpu_rd = 1'b0;
    req    = 4'b0001;
    tick();
`else
    check("no_tmo_feature", 32'(timeout_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
